// File: rtl/reel_pixel_renderer.sv
// Slot-machine reel pixel renderer: maps VGA timing to three scrolling reel
// windows, fetches texels from an external synchronous ROM and drives RGB332
// with syncs delayed to match the three-stage pixel pipeline.
module reel_pixel_renderer #(
    parameter logic [9:0] REEL_Y0      = 10'd48,
    parameter logic [7:0] BG_COLOR     = 8'h01,
    parameter logic [7:0] BORDER_COLOR = 8'hF4,
    parameter logic [7:0] LINE_COLOR   = 8'hFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        active_video,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [1:0]  wr_reel,
    input  logic [9:0]  wr_offset,
    input  logic        win_line,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    typedef enum logic [2:0] {
        REG_BLANK,
        REG_LINE,
        REG_WINDOW,
        REG_BORDER,
        REG_BG
    } region_t;

    localparam logic [9:0] WIN_Y1 = REEL_Y0 + 10'd384;
    localparam logic [9:0] BRD_Y0 = REEL_Y0 - 10'd4;
    localparam logic [9:0] BRD_Y1 = REEL_Y0 + 10'd388;

    logic [9:0]  shadow0, shadow1, shadow2;
    logic [9:0]  offset0, offset1, offset2;
    logic        win_line_active;
    logic        commit;

    logic [10:0] x;
    logic [9:0]  y;
    logic [2:0]  in_w, in_b;
    logic [1:0]  reel_sel;
    logic [10:0] reel_x0;
    logic [9:0]  off_sel;
    logic [2:0]  sym_base;
    logic [9:0]  strip_row;
    logic [10:0] x_rel;
    logic        in_window, in_border, on_line;
    region_t     region_next;
    logic [12:0] addr_next;
    logic        unused_bits;

    region_t     region1, region2;
    logic [2:0]  hs_pipe, vs_pipe;
    logic [7:0]  color_q;

    assign x      = hcount - 11'd144;
    assign y      = vcount - 10'd35;
    assign commit = (hcount == 11'd0) && (vcount == 10'd0);

    // Low strip/column bits fall below the 4x texel scale and are not needed.
    assign unused_bits = &{1'b0, strip_row[1:0], x_rel[10:7], x_rel[1:0]};

    // Classify the current pixel and build the texel ROM address.
    always_comb begin
        in_w = {(x >= 11'd448) && (x < 11'd576),
                (x >= 11'd256) && (x < 11'd384),
                (x >= 11'd64)  && (x < 11'd192)};
        in_b = {(x >= 11'd444) && (x < 11'd580),
                (x >= 11'd252) && (x < 11'd388),
                (x >= 11'd60)  && (x < 11'd196)};
        reel_sel = 2'd0;
        reel_x0  = 11'd64;
        off_sel  = offset0;
        sym_base = 3'd0;
        if (in_b[1]) begin
            reel_sel = 2'd1;
            reel_x0  = 11'd256;
            off_sel  = offset1;
            sym_base = 3'd3;
        end else if (in_b[2]) begin
            reel_sel = 2'd2;
            reel_x0  = 11'd448;
            off_sel  = offset2;
            sym_base = 3'd6;
        end
        strip_row = y - REEL_Y0 + off_sel;
        x_rel     = x - reel_x0;
        in_window = active_video && (y >= REEL_Y0) && (y < WIN_Y1) && (|in_w);
        in_border = active_video && (y >= BRD_Y0) && (y < BRD_Y1) && (|in_b) && !in_window;
        on_line   = in_window && win_line_active && ((y == 10'd239) || (y == 10'd240));
        if (!active_video)   region_next = REG_BLANK;
        else if (on_line)    region_next = REG_LINE;
        else if (in_window)  region_next = REG_WINDOW;
        else if (in_border)  region_next = REG_BORDER;
        else                 region_next = REG_BG;
        addr_next = {strip_row[9:7] + sym_base, strip_row[6:2], x_rel[6:2]};
    end

    // Shadow offset writes from the MCU and atomic commit at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow0         <= '0;
            shadow1         <= '0;
            shadow2         <= '0;
            offset0         <= '0;
            offset1         <= '0;
            offset2         <= '0;
            win_line_active <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_reel)
                    2'd0:    shadow0 <= wr_offset;
                    2'd1:    shadow1 <= wr_offset;
                    2'd2:    shadow2 <= wr_offset;
                    default: ;
                endcase
            end
            // Commit reads the pre-write shadows, so a same-cycle write waits a frame.
            if (commit) begin
                offset0         <= shadow0;
                offset1         <= shadow1;
                offset2         <= shadow2;
                win_line_active <= win_line;
            end
            frame_start <= commit;
        end
    end

    // Three-stage pixel pipeline: address/region, ROM wait, colour select.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            region1  <= REG_BLANK;
            region2  <= REG_BLANK;
            hs_pipe  <= 3'b111;
            vs_pipe  <= 3'b111;
            color_q  <= '0;
        end else begin
            rom_addr <= addr_next;
            region1  <= region_next;
            region2  <= region1;
            hs_pipe  <= {hs_pipe[1:0], hsync_in};
            vs_pipe  <= {vs_pipe[1:0], vsync_in};
            case (region2)
                REG_BLANK:  color_q <= 8'h00;
                REG_LINE:   color_q <= LINE_COLOR;
                REG_WINDOW: color_q <= rom_data;
                REG_BORDER: color_q <= BORDER_COLOR;
                default:    color_q <= BG_COLOR;
            endcase
        end
    end

    assign red   = color_q[7:5];
    assign green = color_q[4:2];
    assign blue  = color_q[1:0];
    assign hsync = hs_pipe[2];
    assign vsync = vs_pipe[2];

endmodule

// File: tb/tb_reel_pixel_renderer.sv
// Directed bench for reel_pixel_renderer; the ROM returns addr[7:0] ^ 8'hA5.
module tb_reel_pixel_renderer;

    logic        clk;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        active_video;
    logic        hsync_in, vsync_in;
    logic        wr_en;
    logic [1:0]  wr_reel;
    logic [9:0]  wr_offset;
    logic        win_line;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        hsync, vsync, frame_start;

    int vectors;
    int miscompares;

    reel_pixel_renderer dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .active_video(active_video), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_reel(wr_reel), .wr_offset(wr_offset), .win_line(win_line),
        .rom_addr(rom_addr), .rom_data(rom_data), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model.
    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic av,
                         input logic hs, input logic vs);
        hcount = h; vcount = v; active_video = av; hsync_in = hs; vsync_in = vs;
    endtask

    task automatic idle();
        drive(11'd10, 10'd2, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic commit_frame();
        drive(11'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
    endtask

    task automatic pixel(input string tag, input int px, input int py, input logic av,
                         input logic do_addr, input logic [12:0] exp_addr, input logic [7:0] exp_rgb);
        drive(11'(px + 144), 10'(py + 35), av, 1'b1, 1'b1);
        step();
        if (do_addr) chk({tag, "_addr"}, 16'(rom_addr), 16'(exp_addr));
        idle();
        step();
        step();
        chk({tag, "_rgb"}, 16'({red, green, blue}), 16'(exp_rgb));
    endtask

    initial begin
        logic [15:0] hp;
        logic [15:0] vp;
        vectors = 0;
        miscompares = 0;
        hp = 16'b1011001110001101;
        vp = 16'b0110110001011010;
        wr_en = 1'b0; wr_reel = 2'd0; wr_offset = 10'd0; win_line = 1'b0;
        reset = 1'b1;
        drive(11'd10, 10'd2, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_rgb",   16'({red, green, blue}), 16'h0000);
        chk("rst_hsync", 16'(hsync), 16'h0001);
        chk("rst_vsync", 16'(vsync), 16'h0001);
        chk("rst_addr",  16'(rom_addr), 16'h0000);
        chk("rst_fs",    16'(frame_start), 16'h0000);
        reset = 1'b0;
        idle();
        step();

        // Sync delay of three cycles, blank pixels stay black.
        for (int i = 0; i < 16; i++) begin
            drive(11'd700, 10'd10, 1'b0, hp[i], vp[i]);
            step();
            if (i >= 2) begin
                chk("sync_h", 16'(hsync), 16'(hp[i-2]));
                chk("sync_v", 16'(vsync), 16'(vp[i-2]));
                chk("sync_rgb", 16'({red, green, blue}), 16'h0000);
            end
        end

        // Commit pulse, one cycle only.
        drive(11'd0, 10'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk("fs_pulse", 16'(frame_start), 16'h0001);
        idle();
        step();
        chk("fs_clear", 16'(frame_start), 16'h0000);

        // Zero offsets.
        pixel("r0_origin", 64, 48, 1'b1, 1'b1, 13'h0000, 8'hA5);
        pixel("r1_origin", 256, 48, 1'b1, 1'b1, 13'h0C00, 8'hA5);
        pixel("r1_texel", 300, 60, 1'b1, 1'b1, 13'h0C6B, 8'hCE);
        pixel("r2_origin", 448, 48, 1'b1, 1'b1, 13'h1800, 8'hA5);
        pixel("inactive", 64, 48, 1'b0, 1'b0, 13'h0000, 8'h00);

        // Mid-frame write is held in shadow until commit.
        wr_en = 1'b1; wr_reel = 2'd0; wr_offset = 10'd1000;
        step();
        wr_en = 1'b0;
        pixel("pre_commit", 64, 48, 1'b1, 1'b1, 13'h0000, 8'hA5);
        commit_frame();
        pixel("off1000", 64, 48, 1'b1, 1'b1, 13'h1F40, 8'hE5);

        // Write on the commit cycle lands one frame late.
        wr_en = 1'b1; wr_reel = 2'd0; wr_offset = 10'd128;
        commit_frame();
        wr_en = 1'b0;
        pixel("commit_wr_old", 64, 48, 1'b1, 1'b1, 13'h1F40, 8'hE5);
        wr_en = 1'b1; wr_reel = 2'd3; wr_offset = 10'd5;
        step();
        wr_en = 1'b0;
        commit_frame();
        pixel("commit_wr_new", 64, 48, 1'b1, 1'b1, 13'h0400, 8'hA5);
        pixel("reel3_r1", 256, 48, 1'b1, 1'b1, 13'h0C00, 8'hA5);
        pixel("reel3_r2", 448, 48, 1'b1, 1'b1, 13'h1800, 8'hA5);

        // Win line and region priority.
        win_line = 1'b1;
        commit_frame();
        win_line = 1'b0;
        pixel("line_239", 100, 239, 1'b1, 1'b0, 13'h0000, 8'hFC);
        pixel("line_240", 500, 240, 1'b1, 1'b0, 13'h0000, 8'hFC);
        pixel("above_line", 100, 238, 1'b1, 1'b1, 13'h09E9, 8'h4C);
        pixel("gap_bg", 200, 239, 1'b1, 1'b0, 13'h0000, 8'h01);
        pixel("border_side", 62, 100, 1'b1, 1'b0, 13'h0000, 8'hF4);
        pixel("border_top", 100, 44, 1'b1, 1'b0, 13'h0000, 8'hF4);
        pixel("above_border", 100, 43, 1'b1, 1'b0, 13'h0000, 8'h01);

        // Reset asserted mid-frame.
        for (int i = 0; i < 3; i++) begin
            drive(11'd244, 10'd300, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("pre_rst_hsync", 16'(hsync), 16'h0000);
        reset = 1'b1;
        step();
        chk("mid_rst_rgb",   16'({red, green, blue}), 16'h0000);
        chk("mid_rst_hsync", 16'(hsync), 16'h0001);
        chk("mid_rst_vsync", 16'(vsync), 16'h0001);
        chk("mid_rst_addr",  16'(rom_addr), 16'h0000);
        reset = 1'b0;
        idle();
        step();
        commit_frame();
        pixel("post_rst_r0", 64, 48, 1'b1, 1'b1, 13'h0000, 8'hA5);
        pixel("post_rst_noline", 100, 239, 1'b1, 1'b1, 13'h05E9, 8'h4C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
